// File: rtl/alu_issue_ctrl.sv
// ALU issue sequencer: accepts one instruction per handshake and walks IDLE -> DECODE -> EXEC -> (WAIT) -> WB.
// Optional flag register: define ALU_FLAGS_EN to add alu_flags/flags_q.
module alu_issue_ctrl #(
   parameter int MUL_TIMEOUT = 16,
   parameter int TOW         = 5
) (
   input  logic        clk,
   input  logic        rst,
   // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
   // the source keeps instr stable while instr_valid is high and instr_ready is low.
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   output logic        en_ALUdec,
   output logic        alu_in_sel,
   output logic [2:0]  rd_addr,
   output logic [2:0]  rs_addr,
   output logic [7:0]  offset,
   output logic [3:0]  alu_op,
   output logic        alu_start,
   input  logic        alu_done,
   output logic        wb_en,
   output logic [2:0]  wb_addr,
   output logic        busy,
`ifdef ALU_FLAGS_EN
   output logic        illegal,
   input  logic [3:0]  alu_flags,
   output logic [3:0]  flags_q
`else
   output logic        illegal
`endif
);

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_CMP = 4'h9;
   localparam logic [3:0] OP_MUL = 4'hA;
   localparam logic [TOW-1:0] TMO_LAST = TOW'(MUL_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WAIT   = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t         state_q;
   state_t         state_d;
   logic [15:0]    instr_q;
   logic [3:0]     op_q;
   logic [TOW-1:0] tmo_cnt_q;
   logic           illegal_q;
   logic           accept;
   logic           bad_op;
   logic           tmo_hit;

   assign op_q   = instr_q[15:12];
   assign accept = (state_q == S_IDLE) && instr_valid;
   assign bad_op = instr[15:12] > OP_MUL;

   always_comb begin
      state_d = state_q;
      tmo_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            // NOP and illegal opcodes are consumed without leaving IDLE
            if (accept && !bad_op && (instr[15:12] != OP_NOP)) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = (op_q == OP_MUL) ? S_WAIT : S_WB;
         S_WAIT: begin
            if (alu_done) begin
               state_d = S_WB;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d = S_IDLE;
               tmo_hit = 1'b1;
            end
         end
         S_WB:     state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         instr_q   <= 16'h0000;
         tmo_cnt_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= (accept && bad_op) || tmo_hit;
         if (accept) instr_q <= instr;
         // counts completed WAIT cycles; cleared whenever WAIT is left or not yet entered
         if ((state_q == S_WAIT) && (state_d == S_WAIT)) tmo_cnt_q <= tmo_cnt_q + TOW'(1);
         else                                            tmo_cnt_q <= '0;
      end
   end

   always_comb begin
      instr_ready = (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      en_ALUdec   = 1'b0;
      alu_in_sel  = 1'b0;
      rd_addr     = 3'd0;
      rs_addr     = 3'd0;
      offset      = 8'h00;
      alu_op      = 4'h0;
      alu_start   = (state_q == S_EXEC);
      wb_en       = 1'b0;
      wb_addr     = 3'd0;
      illegal     = illegal_q;
      // operand controls are held from DECODE through WB
      if (state_q != S_IDLE) begin
         en_ALUdec  = 1'b1;
         alu_in_sel = ~instr_q[11];
         rd_addr    = instr_q[10:8];
         rs_addr    = instr_q[7:5];
         offset     = instr_q[7:0];
         alu_op     = op_q;
      end
      if ((state_q == S_WB) && (op_q != OP_CMP)) begin
         wb_en   = 1'b1;
         wb_addr = instr_q[10:8];
      end
   end

`ifdef ALU_FLAGS_EN
   localparam logic [3:0] OP_MOV = 4'h8;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                         flags_q <= 4'b0000;
      else if ((state_q == S_WB) && (op_q != OP_MOV)) flags_q <= alu_flags;
   end
`endif

endmodule
